rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_arbiter_if.sv | 36 +++
 rtl/rom_arb_stats.sv | 31 +++
 rtl/rom_arbiter.sv | 84 ++++++++
 tb/tb_rom_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared defaults, owner tag and helpers for the two-port ROM arbiter.
package rom_arb_pkg;

  localparam int ADDR_W_DEFAULT     = 10;
  localparam int DATA_W_DEFAULT     = 18;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STAT_W             = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int starve_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Fetch/debug request ports plus the synchronous ROM port, bundled for the arbiter.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic              F_REQ;
  logic [ADDR_W-1:0] F_ADDR;
  logic              F_GNT;
  logic              F_RVALID;
  logic [DATA_W-1:0] F_DATA;

  logic              D_REQ;
  logic [ADDR_W-1:0] D_ADDR;
  logic              D_GNT;
  logic              D_RVALID;
  logic [DATA_W-1:0] D_DATA;

  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;

  // The arbiter side.
  modport slave (
    input  F_REQ, F_ADDR, D_REQ, D_ADDR, ROM_DATA,
    output F_GNT, F_RVALID, F_DATA, D_GNT, D_RVALID, D_DATA, ROM_ADDR
  );

  // The requester and ROM side.
  modport master (
    output F_REQ, F_ADDR, D_REQ, D_ADDR, ROM_DATA,
    input  F_GNT, F_RVALID, F_DATA, D_GNT, D_RVALID, D_DATA, ROM_ADDR
  );

endinterface

// File: rtl/rom_arb_stats.sv
// Saturating per-port grant counters; only built when ROM_ARB_STATS_EN is defined.
`ifdef ROM_ARB_STATS_EN
module rom_arb_stats
  import rom_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              f_gnt,
  input  logic              d_gnt,
  output logic [STAT_W-1:0] F_CNT,
  output logic [STAT_W-1:0] D_CNT
);

  localparam logic [STAT_W-1:0] CNT_TOP = '1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      F_CNT <= '0;
      D_CNT <= '0;
    end else begin
      if (f_gnt && (F_CNT != CNT_TOP)) begin
        F_CNT <= F_CNT + STAT_W'(1);
      end
      if (d_gnt && (D_CNT != CNT_TOP)) begin
        D_CNT <= D_CNT + STAT_W'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/rom_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a 1-cycle synchronous ROM.
// Optional grant statistics are enabled by defining ROM_ARB_STATS_EN.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  rom_arbiter_if.slave      bus
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] F_CNT,
  output logic [STAT_W-1:0] D_CNT
`endif
);

  localparam int            SW         = starve_cnt_w(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              f_gnt, d_gnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Fetch wins unless debug has already watched STARVE_MAX fetch grants go by.
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    rom_addr = bus.F_ADDR;
    owner_d  = OWN_NONE;
    starve_d = '0;
    if (RST_N) begin
      if (bus.D_REQ && (!bus.F_REQ || (starve_q == STARVE_TOP))) begin
        d_gnt = 1'b1;
      end else if (bus.F_REQ) begin
        f_gnt = 1'b1;
      end
      if (d_gnt) begin
        rom_addr = bus.D_ADDR;
        owner_d  = OWN_D;
      end else if (f_gnt) begin
        owner_d  = OWN_F;
      end
      if (bus.D_REQ && f_gnt && (starve_q != STARVE_TOP)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  assign rom_data     = bus.ROM_DATA;
  assign bus.ROM_ADDR = rom_addr;
  assign bus.F_GNT    = f_gnt;
  assign bus.D_GNT    = d_gnt;
  assign bus.F_RVALID = (owner_q == OWN_F);
  assign bus.D_RVALID = (owner_q == OWN_D);
  assign bus.F_DATA   = rom_data;
  assign bus.D_DATA   = rom_data;

`ifdef ROM_ARB_STATS_EN
  rom_arb_stats u_stats (
    .CLK   (CLK),
    .RST_N (RST_N),
    .f_gnt (f_gnt),
    .d_gnt (d_gnt),
    .F_CNT (F_CNT),
    .D_CNT (D_CNT)
  );
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 18;
  localparam int SMAX = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ROM_ARB_STATS_EN
  logic [15:0] F_CNT, D_CNT;
`endif

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
`ifdef ROM_ARB_STATS_EN
    ,
    .F_CNT (F_CNT),
    .D_CNT (D_CNT)
`endif
  );

  logic [DW-1:0] romMem [0:(1<<AW)-1];
  always @(posedge CLK) bus.ROM_DATA <= romMem[bus.ROM_ADDR];

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: who was granted last cycle and at which address, fetch grants seen while debug waits.
  int          waitGrants = 0;
  int          prevOwner  = 0;
  logic [AW-1:0] prevAddr = '0;
  int          fTotal     = 0;
  int          dTotal     = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit fReq, input logic [AW-1:0] fAddr,
                               input bit dReq, input logic [AW-1:0] dAddr);
    bus.F_REQ  = fReq;
    bus.F_ADDR = fAddr;
    bus.D_REQ  = dReq;
    bus.D_ADDR = dAddr;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge CLK) begin
    bit            expF, expD;
    logic [AW-1:0] expAddr;
    if (!RST_N) begin
      checkOutput("rst_f_gnt", bus.F_GNT, 0);
      checkOutput("rst_d_gnt", bus.D_GNT, 0);
      checkOutput("rst_f_rvalid", bus.F_RVALID, 0);
      checkOutput("rst_d_rvalid", bus.D_RVALID, 0);
      checkOutput("rst_rom_addr", bus.ROM_ADDR, bus.F_ADDR);
`ifdef ROM_ARB_STATS_EN
      checkOutput("rst_f_cnt", F_CNT, 0);
      checkOutput("rst_d_cnt", D_CNT, 0);
`endif
      waitGrants = 0;
      prevOwner  = 0;
      fTotal     = 0;
      dTotal     = 0;
    end else begin
      expD    = bus.D_REQ && (!bus.F_REQ || (waitGrants >= SMAX));
      expF    = bus.F_REQ && !expD;
      expAddr = expD ? bus.D_ADDR : bus.F_ADDR;
      checkOutput("f_gnt", bus.F_GNT, expF);
      checkOutput("d_gnt", bus.D_GNT, expD);
      checkOutput("rom_addr", bus.ROM_ADDR, expAddr);
      checkOutput("f_rvalid", bus.F_RVALID, prevOwner == 1);
      checkOutput("d_rvalid", bus.D_RVALID, prevOwner == 2);
      if (prevOwner == 1) checkOutput("f_data", bus.F_DATA, romMem[prevAddr]);
      if (prevOwner == 2) checkOutput("d_data", bus.D_DATA, romMem[prevAddr]);
`ifdef ROM_ARB_STATS_EN
      checkOutput("f_cnt", F_CNT, (fTotal > 65535) ? 65535 : fTotal);
      checkOutput("d_cnt", D_CNT, (dTotal > 65535) ? 65535 : dTotal);
`endif
      prevOwner = expF ? 1 : (expD ? 2 : 0);
      prevAddr  = expAddr;
      if (expF) fTotal++;
      if (expD) dTotal++;
      if (expD || !bus.D_REQ) waitGrants = 0;
      else if (expF) waitGrants++;
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) romMem[i] = DW'($urandom);
    applyStimulus(0, 10'h0AA, 0, 10'h000);

    // Reset state.
    @(negedge CLK);
    checkOutput("reset_f_gnt", bus.F_GNT, 0);
    checkOutput("reset_rom_addr", bus.ROM_ADDR, 10'h0AA);
    nextCycle();
    RST_N = 1'b1;

    // Single fetch, granted in the first cycle after release.
    applyStimulus(1, 10'h005, 0, 10'h000);
    @(negedge CLK);
    checkOutput("single_f_gnt", bus.F_GNT, 1);
    checkOutput("single_rom_addr", bus.ROM_ADDR, 10'h005);
    nextCycle();
    applyStimulus(0, 10'h005, 0, 10'h000);
    @(negedge CLK);
    checkOutput("single_f_rvalid", bus.F_RVALID, 1);
    checkOutput("single_f_data", bus.F_DATA, romMem[10'h005]);
    checkOutput("single_d_rvalid", bus.D_RVALID, 0);

    // Starvation: four fetch grants, then debug wins the fifth cycle.
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      applyStimulus(1, AW'(10'h100 + k), 1, 10'h3FF);
      @(negedge CLK);
      checkOutput($sformatf("starve_f_gnt%0d", k), bus.F_GNT, k < 4);
      checkOutput($sformatf("starve_d_gnt%0d", k), bus.D_GNT, k == 4);
    end
    nextCycle();
    applyStimulus(1, 10'h104, 0, 10'h000);
    @(negedge CLK);
    checkOutput("starve_d_rvalid", bus.D_RVALID, 1);
    checkOutput("starve_d_data", bus.D_DATA, romMem[10'h3FF]);
    checkOutput("starve_resume", bus.F_GNT, 1);

    // Alternating ports, one grant per cycle.
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      if (k % 2 == 0) applyStimulus(1, AW'(10'h200 + k), 0, 10'h000);
      else            applyStimulus(0, 10'h000, 1, AW'(10'h300 + k));
      @(negedge CLK);
      checkOutput($sformatf("alt_gnt%0d", k), k % 2 == 0 ? bus.F_GNT : bus.D_GNT, 1);
      if (k > 0) begin
        checkOutput($sformatf("alt_f_rv%0d", k), bus.F_RVALID, (k - 1) % 2 == 0);
        checkOutput($sformatf("alt_d_rv%0d", k), bus.D_RVALID, (k - 1) % 2 == 1);
      end
    end

    // Idle: no grants, ROM address follows F_ADDR.
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      applyStimulus(0, AW'(10'h050 + 7 * k), 0, 10'h3C0);
      @(negedge CLK);
      checkOutput($sformatf("idle_gnt%0d", k), {bus.F_GNT, bus.D_GNT}, 0);
      checkOutput($sformatf("idle_rom_addr%0d", k), bus.ROM_ADDR, AW'(10'h050 + 7 * k));
      if (k > 0) checkOutput($sformatf("idle_rv%0d", k), {bus.F_RVALID, bus.D_RVALID}, 0);
    end

    // Reset right after a debug grant kills its read.
    nextCycle();
    applyStimulus(0, 10'h000, 1, 10'h0AB);
    @(negedge CLK);
    checkOutput("rstgnt_d_gnt", bus.D_GNT, 1);
    nextCycle();
    RST_N = 1'b0;
    applyStimulus(1, 10'h012, 0, 10'h000);
    @(negedge CLK);
    checkOutput("rstgnt_d_rvalid", bus.D_RVALID, 0);
    checkOutput("rstgnt_rom_addr", bus.ROM_ADDR, 10'h012);
    nextCycle();
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("rstgnt_f_gnt", bus.F_GNT, 1);
    checkOutput("rstgnt_d_rvalid2", bus.D_RVALID, 0);
    nextCycle();
    applyStimulus(0, 10'h000, 0, 10'h000);
    @(negedge CLK);
    checkOutput("rstgnt_f_data", bus.F_DATA, romMem[10'h012]);

`ifdef ROM_ARB_STATS_EN
    // Ten fetch and two debug grants from a clean reset.
    nextCycle();
    RST_N = 1'b0;
    nextCycle();
    RST_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) applyStimulus(1, AW'(k), 0, 10'h000);
      else        applyStimulus(0, 10'h000, 1, AW'(k));
      nextCycle();
    end
    applyStimulus(0, 10'h000, 0, 10'h000);
    @(negedge CLK);
    checkOutput("stats_f_cnt", F_CNT, 10);
    checkOutput("stats_d_cnt", D_CNT, 2);
    nextCycle();
    RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("stats_clr_f", F_CNT, 0);
    checkOutput("stats_clr_d", D_CNT, 0);
    nextCycle();
    RST_N = 1'b1;
`endif

    // Random traffic; requesters hold REQ/ADDR until granted.
    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      RST_N = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      if (!bus.F_REQ || prevOwner == 1) begin
        bus.F_REQ  = ($urandom_range(0, 3) != 0);
        bus.F_ADDR = AW'($urandom);
      end
      if (!bus.D_REQ || prevOwner == 2) begin
        bus.D_REQ  = ($urandom_range(0, 1) != 0);
        bus.D_ADDR = AW'($urandom);
      end
    end
    nextCycle();
    RST_N = 1'b1;
    applyStimulus(0, 10'h000, 0, 10'h000);
    @(negedge CLK);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
